inst_fetch: RTL

- Instruction-fetch stage sitting directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM byte address each cycle.
- Absorbs the ROM's one-cycle registered read latency and buffers returned words in a 2-entry queue.
- Hands {instruction, pc} to decode over a valid/ready handshake; accepts branch/jump redirects with zero issue bubble.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_fetch_if.sv | 25 ++
 rtl/inst_fetch_fetch_queue.sv | 82 ++++++++
 rtl/inst_fetch.sv | 94 +++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared widths and helpers for the instruction-fetch stage.
package inst_fetch_pkg;

   localparam int unsigned ROM_ADDRESS_BITWIDTH = 12;
   localparam int unsigned RESET_PC_DEFAULT     = 0;
   localparam int unsigned INST_W               = 32;
   localparam int unsigned FIFO_DEPTH           = 2;
   localparam int unsigned CNT_W                = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OCC_W                = CNT_W + 1;

   // True when queued + in-flight words, less the word leaving this cycle,
   // still leave room for one more fetch.
   function automatic logic has_credit(input logic [CNT_W-1:0] count,
                                       input logic             inflight,
                                       input logic             pop);
      return (OCC_W'(count) + OCC_W'(inflight)) < (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handshake plus the redirect request from execute.
interface inst_fetch_if
   import inst_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = ROM_ADDRESS_BITWIDTH
) ();

   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;

   modport master (
      output inst_valid, inst, inst_pc,
      input  inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  inst_valid, inst, inst_pc,
      output inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/inst_fetch_fetch_queue.sv
// Two-entry instruction queue; head slot drives decode directly.
module inst_fetch_fetch_queue
   import inst_fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = ROM_ADDRESS_BITWIDTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [INST_W-1:0] push_inst,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic              pop,
   input  logic              flush,
   output logic              head_valid,
   output logic [INST_W-1:0] head_inst,
   output logic [ADDR_W-1:0] head_pc,
   output logic [CNT_W-1:0]  count
);

   // vld_q[0] = head slot, vld_q[1] = tail slot; tail valid implies head valid.
   logic [1:0]        vld_q,       vld_d;
   logic [INST_W-1:0] head_inst_q, head_inst_d;
   logic [ADDR_W-1:0] head_pc_q,   head_pc_d;
   logic [INST_W-1:0] tail_inst_q, tail_inst_d;
   logic [ADDR_W-1:0] tail_pc_q,   tail_pc_d;

   assign head_valid = vld_q[0];
   assign head_inst  = head_inst_q;
   assign head_pc    = head_pc_q;
   assign count      = CNT_W'(vld_q[0]) + CNT_W'(vld_q[1]);

   // Next slot contents: pop shifts first, push lands in the first free slot, flush drops all.
   always_comb begin
      vld_d       = vld_q;
      head_inst_d = head_inst_q;
      head_pc_d   = head_pc_q;
      tail_inst_d = tail_inst_q;
      tail_pc_d   = tail_pc_q;
      if (flush) begin
         vld_d = 2'b00;
      end else begin
         if (pop && vld_q[0]) begin
            if (vld_q[1]) begin
               head_inst_d = tail_inst_q;
               head_pc_d   = tail_pc_q;
               vld_d       = 2'b01;
            end else begin
               vld_d       = 2'b00;
            end
         end
         if (push) begin
            if (!vld_d[0]) begin
               head_inst_d = push_inst;
               head_pc_d   = push_pc;
               vld_d[0]    = 1'b1;
            end else if (!vld_d[1]) begin
               tail_inst_d = push_inst;
               tail_pc_d   = push_pc;
               vld_d[1]    = 1'b1;
            end
         end
      end
   end

   // Slot registers; reset clears both valid flags and the stored words.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_q       <= 2'b00;
         head_inst_q <= '0;
         head_pc_q   <= '0;
         tail_inst_q <= '0;
         tail_pc_q   <= '0;
      end else begin
         vld_q       <= vld_d;
         head_inst_q <= head_inst_d;
         head_pc_q   <= head_pc_d;
         tail_inst_q <= tail_inst_d;
         tail_pc_q   <= tail_pc_d;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues ROM reads and queues returned words for decode.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ROM_ADDRESS_BITWIDTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [INST_W-1:0] rom_data,
   inst_fetch_if.master      dec
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic [ADDR_W-1:0] pc_q,          pc_d;
   logic              inflight_q,    inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

   logic              pop_c;
   logic              redirect_c;
   logic [ADDR_W-1:0] target_c;
   logic              issue_c;
   logic              push_c;
   logic [CNT_W-1:0]  q_count;
   logic              unused_lsb_c;

   assign unused_lsb_c = ^dec.redirect_pc[1:0];

   // Handshake and issue decisions; issue looks at inst_ready combinationally.
   assign pop_c      = dec.inst_valid & dec.inst_ready;
   assign redirect_c = dec.redirect_valid;
   assign target_c   = {dec.redirect_pc[ADDR_W-1:2], 2'b00};
   assign issue_c    = redirect_c | has_credit(q_count, inflight_q, pop_c);
   assign push_c     = inflight_q & ~redirect_c;

   // ROM address: reset vector while in reset, redirect target bypasses the PC register.
   always_comb begin
      rom_address = pc_q;
      if (!reset_n) begin
         rom_address = RESET_PC;
      end else if (redirect_c) begin
         rom_address = target_c;
      end
   end

   // Next PC and in-flight tracking.
   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (redirect_c) begin
         pc_d          = target_c + PC_STEP;
         inflight_d    = 1'b1;
         inflight_pc_d = target_c;
      end else if (issue_c) begin
         pc_d          = pc_q + PC_STEP;
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
      end
   end

   // PC and in-flight registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Returned ROM words are queued unless a redirect discards them.
   inst_fetch_fetch_queue #(
      .ADDR_W (ADDR_W)
   ) u_fetch_queue (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push_c),
      .push_inst  (rom_data),
      .push_pc    (inflight_pc_q),
      .pop        (pop_c),
      .flush      (redirect_c),
      .head_valid (dec.inst_valid),
      .head_inst  (dec.inst),
      .head_pc    (dec.inst_pc),
      .count      (q_count)
   );

endmodule
